// File: rtl/snowbro2_video_timing.sv
// Raster timing generator: pixel/line counters, blanking and sync flags,
// vblank strobe and a latched vertical interrupt request for the CPU.
// Everything is registered; flags are derived from the next counter values
// so they move on the same enabled edge as the counters.
module snowbro2_video_timing #(
    parameter int H_TOTAL  = 432,
    parameter int H_ACTIVE = 320,
    parameter int HS_START = 352,
    parameter int HS_END   = 384,
    parameter int V_TOTAL  = 262,
    parameter int V_ACTIVE = 240,
    parameter int VS_START = 248,
    parameter int VS_END   = 251
) (
    input  logic       CLK96,
    input  logic       RESET96,
    input  logic       CEN675,
    input  logic       INT_ACK,
    output logic [8:0] HCNT,
    output logic [8:0] VCNT,
    output logic       HBLANK,
    output logic       VBLANK,
    output logic       HSYNC_N,
    output logic       VSYNC_N,
    output logic       VINT_REQ,
    output logic       VBL_STB,
    output logic       FIELD
);

    localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_ACT   = 9'(H_ACTIVE);
    localparam logic [8:0] HS_B    = 9'(HS_START);
    localparam logic [8:0] HS_E    = 9'(HS_END);
    localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_ACT   = 9'(V_ACTIVE);
    localparam logic [8:0] V_PREBL = 9'(V_ACTIVE - 1);
    localparam logic [8:0] VS_B    = 9'(VS_START);
    localparam logic [8:0] VS_E    = 9'(VS_END);

    logic [8:0] hcnt_q, hcnt_d;
    logic [8:0] vcnt_q, vcnt_d;
    logic       hblank_q, hblank_d;
    logic       vblank_q, vblank_d;
    logic       hsync_n_q, hsync_n_d;
    logic       vsync_n_q, vsync_n_d;
    logic       vint_req_q, vint_req_d;
    logic       vbl_stb_q, vbl_stb_d;
    logic       field_q, field_d;
    logic       line_end, frame_end;

    // Next-state: counters advance only on enabled edges; flags follow the
    // next counter values; the interrupt latch sees every clock.
    always_comb begin
        line_end   = (hcnt_q == H_LAST);
        frame_end  = (vcnt_q == V_LAST);
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        field_d    = field_q;
        vbl_stb_d  = 1'b0;
        vint_req_d = INT_ACK ? 1'b0 : vint_req_q;

        if (CEN675) begin
            hcnt_d = line_end ? 9'd0 : hcnt_q + 9'd1;
            if (line_end) begin
                vcnt_d = frame_end ? 9'd0 : vcnt_q + 9'd1;
                if (frame_end)
                    field_d = ~field_q;
                if (vcnt_q == V_PREBL)
                    vbl_stb_d = 1'b1;
            end
        end

        // A new vblank beats a simultaneous acknowledge
        if (vbl_stb_d)
            vint_req_d = 1'b1;

        hblank_d  = (hcnt_d >= H_ACT);
        vblank_d  = (vcnt_d >= V_ACT);
        hsync_n_d = !((hcnt_d >= HS_B) && (hcnt_d < HS_E));
        vsync_n_d = !((vcnt_d >= VS_B) && (vcnt_d < VS_E));
    end

    // State register with asynchronous reset to the idle top-left position
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            hcnt_q     <= 9'd0;
            vcnt_q     <= 9'd0;
            hblank_q   <= 1'b0;
            vblank_q   <= 1'b0;
            hsync_n_q  <= 1'b1;
            vsync_n_q  <= 1'b1;
            vint_req_q <= 1'b0;
            vbl_stb_q  <= 1'b0;
            field_q    <= 1'b0;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            hblank_q   <= hblank_d;
            vblank_q   <= vblank_d;
            hsync_n_q  <= hsync_n_d;
            vsync_n_q  <= vsync_n_d;
            vint_req_q <= vint_req_d;
            vbl_stb_q  <= vbl_stb_d;
            field_q    <= field_d;
        end
    end

    assign HCNT     = hcnt_q;
    assign VCNT     = vcnt_q;
    assign HBLANK   = hblank_q;
    assign VBLANK   = vblank_q;
    assign HSYNC_N  = hsync_n_q;
    assign VSYNC_N  = vsync_n_q;
    assign VINT_REQ = vint_req_q;
    assign VBL_STB  = vbl_stb_q;
    assign FIELD    = field_q;

endmodule

// File: tb/tb_snowbro2_video_timing.sv
// Directed bench: a default-geometry instance for line timing and a shrunken
// instance for frame, strobe and interrupt behaviour; both share stimulus.
module tb_snowbro2_video_timing;

    logic clk = 1'b0;
    logic rst, cen, ack;
    always #5 clk = ~clk;

    logic [8:0] a_h, a_v, b_h, b_v;
    logic a_hb, a_vb, a_hs, a_vs, a_vi, a_st, a_fd;
    logic b_hb, b_vb, b_hs, b_vs, b_vi, b_st, b_fd;

    snowbro2_video_timing dut_a (
        .CLK96(clk), .RESET96(rst), .CEN675(cen), .INT_ACK(ack),
        .HCNT(a_h), .VCNT(a_v), .HBLANK(a_hb), .VBLANK(a_vb),
        .HSYNC_N(a_hs), .VSYNC_N(a_vs), .VINT_REQ(a_vi), .VBL_STB(a_st), .FIELD(a_fd)
    );

    snowbro2_video_timing #(
        .H_TOTAL(16), .H_ACTIVE(10), .HS_START(12), .HS_END(14),
        .V_TOTAL(8), .V_ACTIVE(5), .VS_START(6), .VS_END(7)
    ) dut_b (
        .CLK96(clk), .RESET96(rst), .CEN675(cen), .INT_ACK(ack),
        .HCNT(b_h), .VCNT(b_v), .HBLANK(b_hb), .VBLANK(b_vb),
        .HSYNC_N(b_hs), .VSYNC_N(b_vs), .VINT_REQ(b_vi), .VBL_STB(b_st), .FIELD(b_fd)
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    // one clock: drive inputs, let the edge happen, sample 1ns later
    task automatic step(input logic c, input logic a);
        cen = c;
        ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " a pos"}, {a_h, a_v}, 18'd0);
        chk({tag, " a flags"}, {a_hb, a_vb, a_hs, a_vs, a_vi, a_st, a_fd}, 7'b0011000);
        chk({tag, " b pos"}, {b_h, b_v}, 18'd0);
        chk({tag, " b flags"}, {b_hb, b_vb, b_hs, b_vs, b_vi, b_st, b_fd}, 7'b0011000);
    endtask

    typedef struct {
        int         pulses;
        logic [8:0] hcnt;
        logic [8:0] vcnt;
        logic       hblank;
        logic       hsync_n;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int done;
        int k;
        int stb_cnt;
        int h, v;
        logic [22:0] expv, actv;

        tbl[0]  = '{0,   9'd0,   9'd0, 1'b0, 1'b1};
        tbl[1]  = '{1,   9'd1,   9'd0, 1'b0, 1'b1};
        tbl[2]  = '{319, 9'd319, 9'd0, 1'b0, 1'b1};
        tbl[3]  = '{320, 9'd320, 9'd0, 1'b1, 1'b1};
        tbl[4]  = '{351, 9'd351, 9'd0, 1'b1, 1'b1};
        tbl[5]  = '{352, 9'd352, 9'd0, 1'b1, 1'b0};
        tbl[6]  = '{383, 9'd383, 9'd0, 1'b1, 1'b0};
        tbl[7]  = '{384, 9'd384, 9'd0, 1'b1, 1'b1};
        tbl[8]  = '{431, 9'd431, 9'd0, 1'b1, 1'b1};
        tbl[9]  = '{432, 9'd0,   9'd1, 1'b0, 1'b1};
        tbl[10] = '{433, 9'd1,   9'd1, 1'b0, 1'b1};

        rst = 1'b1; cen = 1'b0; ack = 1'b0;
        #1;
        chk_reset_vals("reset t0");
        step(1, 0); step(1, 0);
        chk_reset_vals("reset held");
        rst = 1'b0;

        // line timing on default geometry, pulses counted from reset
        done = 0;
        foreach (tbl[i]) begin
            while (done < tbl[i].pulses) begin
                step(0, 0);
                step(1, 0);
                done++;
            end
            chk($sformatf("line p%0d", tbl[i].pulses),
                {a_h, a_v, a_hb, a_hs},
                {tbl[i].hcnt, tbl[i].vcnt, tbl[i].hblank, tbl[i].hsync_n});
        end

        // frame behaviour on small geometry (16 x 8), continuous enable
        rst = 1'b1; step(0, 0); rst = 1'b0;
        stb_cnt = 0;
        for (k = 1; k <= 340; k++) begin
            step(1, 0);
            h = k % 16;
            v = (k / 16) % 8;
            expv = {9'(h), 9'(v), (h >= 10), !(h >= 12 && h < 14), (v >= 5),
                    !(v == 6), ((k / 128) % 2 == 1)};
            actv = {b_h, b_v, b_hb, b_hs, b_vb, b_vs, b_fd};
            chk($sformatf("frame k%0d", k), actv, expv);
            chk($sformatf("stb k%0d", k), b_st, (h == 0 && v == 5));
            chk($sformatf("vint k%0d", k), b_vi, (k >= 80));
            if (b_st) stb_cnt++;
        end
        chk("stb count", stb_cnt, 3);

        // enable low for 100 clocks: everything frozen, request still pending
        for (int i = 0; i < 100; i++) step(0, 0);
        chk("freeze a", {a_h, a_v, a_hb, a_vb, a_hs, a_vs, a_fd}, {9'd340, 9'd0, 5'b10110});
        chk("freeze b", {b_h, b_v, b_hb, b_vb, b_hs, b_vs, b_fd}, {9'd4, 9'd5, 5'b01110});
        chk("freeze vint", {b_vi, b_st}, 2'b10);

        // acknowledge works with enable low
        step(0, 1);
        chk("ack clears", b_vi, 1'b0);
        chk("ack b pos", {b_h, b_v}, {9'd4, 9'd5});
        step(0, 0);
        chk("ack stays clear", b_vi, 1'b0);

        // run up to the next vblank edge (k=464) and ack on that same edge
        for (k = 341; k < 464; k++) step(1, 0);
        chk("pre-set vint", {b_vi, b_st, b_h, b_v}, {2'b00, 9'd15, 9'd4});
        step(1, 1);
        chk("set beats ack", {b_vi, b_st, b_h, b_v}, {2'b11, 9'd0, 9'd5});
        step(0, 1);
        chk("stb single, ack", {b_vi, b_st}, 2'b00);
        ack = 1'b0;

        // move to a_h=200 (dut_b lands at line 7 of its frame), reset asynchronously
        for (k = 465; k <= 632; k++) step(1, 0);
        chk("pre-reset a", {a_h, a_v, a_hb}, {9'd200, 9'd1, 1'b0});
        chk("pre-reset b", {b_h, b_v, b_vb}, {9'd8, 9'd7, 1'b1});
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("async reset");
        step(1, 0);
        rst = 1'b0;
        chk_reset_vals("reset w/ cen");
        step(1, 0);
        chk("restart a", {a_h, a_v}, {9'd1, 9'd0});
        chk("restart b", {b_h, b_v}, {9'd1, 9'd0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/snowbro2_video_timing.md
SNOWBRO2_VIDEO_TIMING -- requirements
Module: snowbro2_video_timing

Interface
REQ-001 SHALL have parameter H_TOTAL, default 432, pixels per line.
REQ-002 SHALL have parameter H_ACTIVE, default 320, visible pixels per line.
REQ-003 SHALL have parameters HS_START, default 352, and HS_END, default 384: HSYNC active for HCNT in [HS_START, HS_END).
REQ-004 SHALL have parameter V_TOTAL, default 262, lines per frame.
REQ-005 SHALL have parameter V_ACTIVE, default 240, visible lines per frame.
REQ-006 SHALL have parameters VS_START, default 248, and VS_END, default 251: VSYNC active for VCNT in [VS_START, VS_END).
REQ-007 CLK96  input  1  the single clock, 94.5 MHz; all state on rising edge.
REQ-008 RESET96  input  1  reset, asynchronous, active-high.
REQ-009 CEN675  input  1  pixel clock enable, one CLK96 cycle wide, nominal 6.75 MHz.
REQ-010 INT_ACK  input  1  CPU acknowledge of the vertical interrupt, level, sampled every CLK96.
REQ-011 HCNT  output  9  horizontal pixel counter.
REQ-012 VCNT  output  9  vertical line counter.
REQ-013 HBLANK  output  1  high while HCNT >= H_ACTIVE.
REQ-014 VBLANK  output  1  high while VCNT >= V_ACTIVE.
REQ-015 HSYNC_N  output  1  horizontal sync, active-low.
REQ-016 VSYNC_N  output  1  vertical sync, active-low.
REQ-017 VINT_REQ  output  1  latched vertical-interrupt request to the 68000.
REQ-018 VBL_STB  output  1  one-CLK96 strobe at vblank start.
REQ-019 FIELD  output  1  toggles once per frame.

Function
REQ-020 SHALL be fully registered; every output is a flop.
REQ-021 SHALL change HCNT, VCNT, HBLANK, VBLANK, HSYNC_N, VSYNC_N, FIELD only on CLK96 edges with CEN675=1; otherwise hold.
REQ-022 SHALL, on each enabled edge, increment HCNT; at HCNT=H_TOTAL-1, load 0 and advance VCNT.
REQ-023 SHALL advance VCNT by 1, and at VCNT=V_TOTAL-1 with line wrap, load 0 and toggle FIELD.
REQ-024 SHALL compute HBLANK, VBLANK, HSYNC_N, VSYNC_N from the next-state counter values so they change on the same edge as the counters that define them (zero-cycle skew).
REQ-025 SHALL assert VBL_STB for exactly one CLK96 cycle on the enabled edge where VCNT becomes V_ACTIVE and HCNT becomes 0.
REQ-026 SHALL set VINT_REQ on the same edge as VBL_STB; VINT_REQ holds until a CLK96 edge with INT_ACK=1 clears it.
REQ-027 SHALL, with set and INT_ACK=1 on the same edge, leave VINT_REQ=1 (set wins).
REQ-028 SHALL leave VINT_REQ at 1 if already set when a new set occurs; no counting of missed interrupts.
REQ-029 SHALL keep INT_ACK effective regardless of CEN675.
REQ-030 SHALL use 9-bit unsigned arithmetic; parameters require H_ACTIVE<HS_START<HS_END<=H_TOTAL<=512, V_ACTIVE<VS_START<VS_END<=V_TOTAL<=512.
REQ-031 SHALL produce a frame period of H_TOTAL*V_TOTAL enabled cycles (113184 at defaults).

Reset
REQ-032 SHALL, while RESET96=1, force immediately: HCNT=0, VCNT=0, HBLANK=0, VBLANK=0, HSYNC_N=1, VSYNC_N=1, VINT_REQ=0, VBL_STB=0, FIELD=0.
REQ-033 SHALL, on reset assertion mid-line or mid-frame, discard all position state; the first enabled edge after release gives HCNT=1, VCNT=0.

Verification
REQ-034 Reset, then 432 CEN675 pulses -> HCNT steps 0..431 then 0, VCNT 0->1 on the 432nd pulse.
REQ-035 Run one line -> HBLANK 1 exactly for HCNT 320..431; HSYNC_N 0 exactly for HCNT 352..383.
REQ-036 Run a full frame -> VBL_STB single CLK96 pulse at VCNT=240/HCNT=0, VSYNC_N 0 for VCNT 248..250, FIELD toggles after 113184 pulses.
REQ-037 VINT_REQ set, INT_ACK held 0 for 2 frames -> stays 1; INT_ACK=1 one cycle -> 0 next edge; INT_ACK=1 coincident with set -> 1.
REQ-038 CEN675 held 0 for 100 CLK96 cycles mid-line -> all outputs frozen; INT_ACK still clears VINT_REQ.
REQ-039 RESET96 pulsed at HCNT=200, VCNT=245 -> all outputs at REQ-032 values without waiting for a clock edge; restart per REQ-033.
